if_prefetch_queue: RTL and testbench

- Parametrised fetch stage that replaces the single-cycle PC register and instruction-memory lookup.
- Issues in-order fetch requests to an instruction memory with variable latency through a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs in a QDEPTH-entry queue, so memory latency is decoupled from decode stalls.
- Supports branch/jump redirect from the Execute stage; responses still in flight at redirect time are discarded.

---
 rtl/if_prefetch_queue.sv | 107 ++++++++++
 tb/tb_if_prefetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: decoupled fetch stage with in-order request issue
// and a small PC/instruction queue in front of decode.
module if_prefetch_queue #(
   parameter int XLEN = 32,
   parameter int QDEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     StallF,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [XLEN-1:0]          imem_req_addr,
   input  logic                     imem_rsp_valid,
   input  logic [XLEN-1:0]          imem_rsp_data,
   output logic                     instr_valid,
   output logic [XLEN-1:0]          instrF,
   output logic [XLEN-1:0]          PCF,
   output logic [XLEN-1:0]          PCPlus4F,
   output logic [$clog2(QDEPTH):0]  occupancy
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] q_pc   [QDEPTH];
   logic [XLEN-1:0] q_data [QDEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard_cnt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW:0]     inflight;
   logic            credit;
   logic            issue;
   logic            push;
   logic            pop;

   assign inflight = {1'b0, count} + {1'b0, outstanding};
   assign credit   = inflight < (CW+1)'(QDEPTH);

   assign imem_req_valid = credit && !redirect_valid && !rst;
   assign imem_req_addr  = fetch_pc;
   assign issue          = imem_req_valid && imem_req_ready;

   assign push = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;
   assign pop  = instr_valid && !StallF && !redirect_valid;

   assign instr_valid = count != '0;
   assign instrF      = q_data[rptr];
   assign PCF         = q_pc[rptr];
   assign PCPlus4F    = PCF + XLEN'(4);
   assign occupancy   = count;

   // fetch pointers, in-flight bookkeeping and queue storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         outstanding <= '0;
         discard_cnt <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc[i]   <= '0;
            q_data[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc;
         rsp_pc      <= redirect_pc;
         rptr        <= wptr;
         count       <= '0;
         outstanding <= outstanding - CW'(imem_rsp_valid);
         discard_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
         if (imem_rsp_valid && (discard_cnt != '0)) begin
            discard_cnt <= discard_cnt - CW'(1);
         end
         if (push) begin
            q_pc[wptr]   <= rsp_pc;
            q_data[wptr] <= imem_rsp_data;
            wptr         <= wptr + AW'(1);
            rsp_pc       <= rsp_pc + XLEN'(4);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // a response with nothing in flight means the memory broke protocol
   rsp_without_req: assert property (
      @(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (outstanding != '0)
   );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: vector table, memory model with scoreboard,
// and hand-written redirect / reset / wrap sequences.
module tb_if_prefetch_queue;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        StallF, redirect_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] redirect_pc, imem_rsp_data;
   logic        imem_req_valid, instr_valid;
   logic [31:0] imem_req_addr, instrF, PCF, PCPlus4F;
   logic [2:0]  occupancy;

   logic        b_ready, b_rsp_valid;
   logic [31:0] b_rsp_data;
   logic        b_rv, b_iv;
   logic [31:0] b_addr, b_instr, b_pcf, b_pc4;
   logic [2:0]  b_occ;

   if_prefetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0000_1000)) u0 (
      .clk(clk), .rst(rst), .StallF(StallF),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
      .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
      .occupancy(occupancy)
   );

   if_prefetch_queue #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u1 (
      .clk(clk), .rst(rst), .StallF(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req_valid(b_rv), .imem_req_ready(b_ready),
      .imem_req_addr(b_addr), .imem_rsp_valid(b_rsp_valid),
      .imem_rsp_data(b_rsp_data), .instr_valid(b_iv),
      .instrF(b_instr), .PCF(b_pcf), .PCPlus4F(b_pc4),
      .occupancy(b_occ)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } sbe_t;

   typedef struct {
      bit          rfirst;
      bit          stall;
      bit          rv;
      logic [31:0] addr;
      bit          v;
      logic [31:0] pcf;
      logic [2:0]  occ;
   } vec_t;

   mreq_t mq[$];
   sbe_t  sb[$];
   vec_t  tbl[22];

   int passed = 0;
   int total = 0;
   int cyc = 0;
   int last_due = 0;
   bit stall, redir, ready;
   int lat;
   logic [31:0] rpc;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // drive one cycle of inputs, sample #1 later, run the scoreboard
   task automatic step();
      sbe_t e;
      int   d;
      cyc++;
      StallF = stall;
      redirect_valid = redir;
      redirect_pc = rpc;
      imem_req_ready = ready;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = mdata(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = '0;
      end
      #1;
      if (redirect_valid) begin
         sb.delete();
      end else if (instr_valid && !StallF) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_empty: got pc %h required no pop", PCF);
         end else begin
            e = sb.pop_front();
            check("sb_pc", PCF, e.pc);
            check("sb_data", instrF, e.data);
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         d = cyc + lat;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mq.push_back('{imem_req_addr, d});
         sb.push_back('{imem_req_addr, mdata(imem_req_addr)});
      end
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic tick();
      step();
      adv();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall = 0; redir = 0; rpc = '0; ready = 0; lat = 1;
      StallF = 0; redirect_valid = 0; redirect_pc = '0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
      b_ready = 0; b_rsp_valid = 0; b_rsp_data = '0;
      mq.delete();
      sb.delete();
      last_due = 0;
      #1;
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_pcf", PCF, 32'h0);
      check("rst_pc4", PCPlus4F, 32'h4);
      check("rst_instr", instrF, 32'h0);
      check("rst_rv", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_head(input string name, input logic [31:0] pc);
      bit found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (instr_valid) begin
            found = 1;
            check({name, "_pc"}, PCF, pc);
            check({name, "_data"}, instrF, mdata(pc));
         end
         adv();
      end
      if (!found) begin
         total++;
         $display("FAIL %s_timeout: got no head required pc %h", name, pc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1, 0, 1, 32'h1000, 0, 32'h0,    3'd0};
      tbl[1]  = '{0, 0, 1, 32'h1004, 0, 32'h0,    3'd0};
      tbl[2]  = '{0, 0, 1, 32'h1008, 1, 32'h1000, 3'd1};
      tbl[3]  = '{0, 0, 1, 32'h100C, 1, 32'h1004, 3'd1};
      tbl[4]  = '{0, 0, 1, 32'h1010, 1, 32'h1008, 3'd1};
      tbl[5]  = '{0, 0, 1, 32'h1014, 1, 32'h100C, 3'd1};
      tbl[6]  = '{1, 1, 1, 32'h1000, 0, 32'h0,    3'd0};
      tbl[7]  = '{0, 1, 1, 32'h1004, 0, 32'h0,    3'd0};
      tbl[8]  = '{0, 1, 1, 32'h1008, 1, 32'h1000, 3'd1};
      tbl[9]  = '{0, 1, 1, 32'h100C, 1, 32'h1000, 3'd2};
      tbl[10] = '{0, 1, 0, 32'h1010, 1, 32'h1000, 3'd3};
      for (int i = 11; i < 18; i++)
         tbl[i] = '{0, 1, 0, 32'h1010, 1, 32'h1000, 3'd4};
      tbl[18] = '{0, 0, 0, 32'h1010, 1, 32'h1000, 3'd4};
      tbl[19] = '{0, 0, 1, 32'h1010, 1, 32'h1004, 3'd3};
      tbl[20] = '{0, 0, 1, 32'h1014, 1, 32'h1008, 3'd2};
      tbl[21] = '{0, 0, 1, 32'h1018, 1, 32'h100C, 3'd2};

      #1;
      do_reset();

      for (int i = 0; i < 22; i++) begin
         if (tbl[i].rfirst) do_reset();
         stall = tbl[i].stall;
         ready = 1;
         lat = 1;
         step();
         check($sformatf("v%0d_rv", i), 32'(imem_req_valid), 32'(tbl[i].rv));
         check($sformatf("v%0d_addr", i), imem_req_addr, tbl[i].addr);
         check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
         check($sformatf("v%0d_pcf", i), PCF, tbl[i].pcf);
         check($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
         adv();
      end

      do_reset();
      ready = 1; lat = 4;
      repeat (3) tick();
      redir = 1; rpc = 32'h2000;
      step();
      check("rd_rv_off", 32'(imem_req_valid), 32'd0);
      adv();
      redir = 0;
      step();
      check("rd_rv", 32'(imem_req_valid), 32'd1);
      check("rd_addr", imem_req_addr, 32'h2000);
      check("rd_occ0", 32'(occupancy), 32'd0);
      adv();
      repeat (2) begin
         step();
         check("rd_occ_drop", 32'(occupancy), 32'd0);
         adv();
      end
      wait_head("rd_head", 32'h2000);

      do_reset();
      ready = 1; lat = 1; stall = 1;
      repeat (3) tick();
      stall = 0; redir = 1; rpc = 32'h3000;
      step();
      check("rp_occ2", 32'(occupancy), 32'd2);
      check("rp_valid", 32'(instr_valid), 32'd1);
      adv();
      redir = 0;
      step();
      check("rp_occ0", 32'(occupancy), 32'd0);
      check("rp_valid0", 32'(instr_valid), 32'd0);
      check("rp_addr", imem_req_addr, 32'h3000);
      adv();
      step();
      check("rp_drop", 32'(occupancy), 32'd0);
      adv();
      wait_head("rp_head", 32'h3000);

      do_reset();
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("nr%0d_rv", k), 32'(imem_req_valid), 32'd1);
         check($sformatf("nr%0d_addr", k), imem_req_addr, 32'h1000);
         adv();
      end
      redir = 1; rpc = 32'h4000;
      step();
      check("nr_redir_rv", 32'(imem_req_valid), 32'd0);
      adv();
      redir = 0;
      step();
      check("nr_after_rv", 32'(imem_req_valid), 32'd1);
      check("nr_after_addr", imem_req_addr, 32'h4000);
      adv();
      ready = 1;
      wait_head("nr_head", 32'h4000);
      repeat (3) tick();
      step();
      check("ar_pre_valid", 32'(instr_valid), 32'd1);
      do_reset();
      ready = 1;
      step();
      check("ar_rv", 32'(imem_req_valid), 32'd1);
      check("ar_addr", imem_req_addr, 32'h1000);
      adv();

      do_reset();
      b_ready = 1;
      #1;
      check("wr_rv", 32'(b_rv), 32'd1);
      check("wr_addr", b_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      b_ready = 0;
      b_rsp_valid = 1;
      b_rsp_data = 32'hCAFE_0001;
      #1;
      check("wr_next", b_addr, 32'h0);
      @(negedge clk);
      b_rsp_valid = 0;
      #1;
      check("wr_valid", 32'(b_iv), 32'd1);
      check("wr_pcf", b_pcf, 32'hFFFF_FFFC);
      check("wr_pc4", b_pc4, 32'h0);
      check("wr_instr", b_instr, 32'hCAFE_0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
